// File: rtl/keypad_pkg.sv
// Shared keypad constants: matrix geometry, key index map and bit helpers.
// Used by the scanner, the debouncer and the password-entry encoder.
package keypad_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEY_W = ROWS * COLS;

  // Key index = row*4 + col; indices 1, 2 and 4 are unused but still reported.
  typedef enum logic [3:0] {
    KEY_ENTER       = 4'd0,
    KEY_3           = 4'd5,
    KEY_2           = 4'd6,
    KEY_1           = 4'd7,
    KEY_0           = 4'd3,
    KEY_CLEAR_ALL   = 4'd8,
    KEY_6           = 4'd9,
    KEY_5           = 4'd10,
    KEY_4           = 4'd11,
    KEY_CLEAR_ENTRY = 4'd12,
    KEY_9           = 4'd13,
    KEY_8           = 4'd14,
    KEY_7           = 4'd15
  } key_e;

  function automatic logic [4:0] popcount16(input logic [KEY_W-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [3:0] onehot_to_index(input logic [KEY_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the board pins, the scanner and
// the password/display logic.
interface keypad_scanner_if;

  logic [keypad_pkg::COLS-1:0]  col;
  logic [keypad_pkg::ROWS-1:0]  row;
  logic [keypad_pkg::KEY_W-1:0] onehot;
  logic [3:0]                   key_code;
  logic                         key_valid;

  modport master (
    input  col,
    output row, onehot, key_code, key_valid
  );

  modport slave (
    output col,
    input  row, onehot, key_code, key_valid
  );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: commits a key state once DEBOUNCE_CNT consecutive
// identical frames are seen, and filters multi-key/ghost frames to zero.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] frame,
  input  logic             frame_done,
  output logic [KEY_W-1:0] onehot,
  output logic [3:0]       key_code,
  output logic             key_valid
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [KEY_W-1:0] prev_frame;
  logic [KEY_W-1:0] candidate;
  logic             cand_pending;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] next_cnt;

  always_comb begin
    next_cnt = CNT_W'(1);
    if (frame == prev_frame) begin
      next_cnt = (stable_cnt == CNT_W'(DEBOUNCE_CNT)) ? stable_cnt
                                                       : stable_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_frame   <= '0;
      candidate    <= '0;
      cand_pending <= 1'b0;
      stable_cnt   <= '0;
      onehot       <= '0;
      key_code     <= '0;
      key_valid    <= 1'b0;
    end else begin
      key_valid    <= 1'b0;
      cand_pending <= 1'b0;
      if (frame_done) begin
        stable_cnt   <= next_cnt;
        prev_frame   <= frame;
        candidate    <= frame;
        cand_pending <= (next_cnt == CNT_W'(DEBOUNCE_CNT));
      end
      // Held keys re-qualify every frame; only a differing candidate commits.
      if (cand_pending && (candidate != onehot)) begin
        if (popcount16(candidate) == 5'd1) begin
          onehot    <= candidate;
          key_code  <= onehot_to_index(candidate);
          key_valid <= 1'b1;
        end else begin
          onehot <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column synchronizer, dwell divider and row
// sequencer feeding a frame-level debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [COLS-1:0]  col_s1;
  logic [COLS-1:0]  col_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [KEY_W-1:0] frame_acc;
  logic [KEY_W-1:0] frame_now;
  logic             terminal;
  logic             frame_done;

  assign terminal   = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_done = terminal && (row_idx == 2'd3);
  assign kp.row     = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1    <= '1;
      col_s2    <= '1;
      div       <= '0;
      row_idx   <= '0;
      frame_acc <= '0;
    end else begin
      col_s1 <= kp.col;
      col_s2 <= col_s1;
      if (terminal) begin
        div     <= '0;
        row_idx <= row_idx + 2'd1;
        frame_acc[{row_idx, 2'b00} +: COLS] <= ~col_s2;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // The row-3 nibble is merged combinationally so the debouncer sees the
  // complete frame on the same cycle as frame_done.
  always_comb begin
    frame_now = frame_acc;
    if (terminal) frame_now[{row_idx, 2'b00} +: COLS] = ~col_s2;
  end

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame_now),
    .frame_done (frame_done),
    .onehot     (kp.onehot),
    .key_code   (kp.key_code),
    .key_valid  (kp.key_valid)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with a behavioural keypad
// and a key-level expectation model (single key -> that key, else zero).
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int          BOUND    = (DEB + 1) * 4 * SCAN_DIV + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_drv;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int seen_nonzero = 0;
  int seen_zero = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    col_drv = '1;
    for (int r = 0; r < 4; r++) begin
      if (!kp.row[r]) col_drv = col_drv & ~pressed[r*4 +: 4];
    end
  end
  assign kp.col = col_drv;

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) pulses++;
    if (kp.onehot !== 16'h0000) seen_nonzero++;
    if (kp.onehot === 16'h0000) seen_zero++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_monitors();
    pulses = 0;
    seen_nonzero = 0;
    seen_zero = 0;
  endtask

  task automatic wait_onehot(input logic [15:0] exp, input string tag);
    int n = 0;
    while (kp.onehot !== exp && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, kp.onehot, exp);
  endtask

  function automatic int ones(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  initial begin
    logic [15:0] exp_oh;
    logic [15:0] prev_oh;
    logic [3:0]  exp_code;
    int          kind;
    int          k1;
    int          k2;
    int          n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row", 16'(kp.row), 16'h000e);
    check("rst_onehot", kp.onehot, 16'h0000);
    check("rst_code", 16'(kp.key_code), 16'h0000);
    check("rst_valid", 16'(kp.key_valid), 16'h0000);
    rst = 1'b0;

    // Key 6 ('2'): press, hold 200 cycles, release
    clear_monitors();
    pressed = 16'h0040;
    wait_onehot(16'h0040, "k6_commit");
    check("k6_code", 16'(kp.key_code), 16'd6);
    repeat (150) @(negedge clk);
    check("k6_held", kp.onehot, 16'h0040);
    check("k6_pulses", 16'(pulses), 16'd1);
    pressed = '0;
    wait_onehot(16'h0000, "k6_release");
    repeat (40) @(negedge clk);
    check("k6_release_pulses", 16'(pulses), 16'd1);
    check("k6_code_hold", 16'(kp.key_code), 16'd6);

    // Mid-scan asynchronous reset while a key is committed
    pressed = 16'h0040;
    wait_onehot(16'h0040, "rst_pre_commit");
    n = 0;
    while (kp.row !== 4'b1011 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_row2", 16'(kp.row), 16'h000b);
    #1 rst = 1'b1;
    #1;
    check("rst_async_row", 16'(kp.row), 16'h000e);
    check("rst_async_onehot", kp.onehot, 16'h0000);
    check("rst_async_valid", 16'(kp.key_valid), 16'h0000);
    pressed = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_row0", 16'(kp.row), 16'h000e);
    @(negedge clk);
    check("restart_row1", 16'(kp.row), 16'h000d);
    repeat (80) @(negedge clk);

    // Key 3 ('0') bouncing for 20 cycles, then held
    clear_monitors();
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (5) @(negedge clk);
    end
    check("bounce_no_commit", 16'(seen_nonzero), 16'd0);
    pressed = 16'h0008;
    wait_onehot(16'h0008, "bounce_commit");
    repeat (40) @(negedge clk);
    check("bounce_pulses", 16'(pulses), 16'd1);
    check("bounce_code", 16'(kp.key_code), 16'd3);
    pressed = '0;
    wait_onehot(16'h0000, "bounce_release");

    // ENTER + CLEAR_ALL together: ghost/multi-key is suppressed
    clear_monitors();
    pressed = 16'h0101;
    repeat (120) @(negedge clk);
    check("multi_never_nonzero", 16'(seen_nonzero), 16'd0);
    check("multi_pulses", 16'(pulses), 16'd0);
    pressed = 16'h0001;
    wait_onehot(16'h0001, "enter_commit");
    repeat (40) @(negedge clk);
    check("enter_pulses", 16'(pulses), 16'd1);
    check("enter_code", 16'(kp.key_code), 16'd0);
    pressed = '0;
    wait_onehot(16'h0000, "enter_release");

    // Key 15 ('7') then directly key 14 ('8') without release
    clear_monitors();
    pressed = 16'h8000;
    wait_onehot(16'h8000, "k15_commit");
    check("k15_code", 16'(kp.key_code), 16'd15);
    repeat (30) @(negedge clk);
    seen_zero = 0;
    pressed = 16'h4000;
    wait_onehot(16'h4000, "k14_commit");
    check("k14_code", 16'(kp.key_code), 16'd14);
    check("switch_no_zero", 16'(seen_zero), 16'd0);
    repeat (40) @(negedge clk);
    check("switch_pulses", 16'(pulses), 16'd2);
    pressed = '0;
    wait_onehot(16'h0000, "k14_release");

    // Press shorter than a frame
    repeat (30) @(negedge clk);
    clear_monitors();
    pressed = 16'h0400;
    repeat (12) @(negedge clk);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("short_never_nonzero", 16'(seen_nonzero), 16'd0);
    check("short_pulses", 16'(pulses), 16'd0);

    // Randomized key patterns against the key-level model
    prev_oh  = 16'h0000;
    exp_code = kp.key_code;
    for (int it = 0; it < 12; it++) begin
      kind = int'($urandom_range(0, 3));
      k1 = int'($urandom_range(0, 15));
      k2 = (k1 + int'($urandom_range(1, 15))) % 16;
      case (kind)
        0:       pressed = 16'h0000;
        3:       pressed = (16'h0001 << k1) | (16'h0001 << k2);
        default: pressed = 16'h0001 << k1;
      endcase
      exp_oh = (ones(pressed) == 1) ? pressed : 16'h0000;
      if (exp_oh != 16'h0000) exp_code = 4'(k1);
      clear_monitors();
      @(negedge clk);
      wait_onehot(exp_oh, "rand_onehot");
      repeat (60) @(negedge clk);
      check("rand_stable", kp.onehot, exp_oh);
      check("rand_code", 16'(kp.key_code), 16'(exp_code));
      check("rand_pulses", 16'(pulses),
            (exp_oh != 16'h0000 && exp_oh != prev_oh) ? 16'd1 : 16'd0);
      prev_oh = exp_oh;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 active-low matrix keypad and debounces the result.
- Produces the 16-bit one-hot key code consumed by the password-entry encoder (onehot2binary).
- Holds that code steady for as long as a single key stays pressed, and returns it to zero on release.
- Sits between the board keypad pins and the password/display logic.

Parameters:
- SCAN_DIV, 50000, clk cycles each row is driven (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_CNT, 4, consecutive identical full-matrix frames required before a new key state is committed; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col  input  4  column sense lines, active-low (pulled up); asynchronous to clk
- row  output 4  row drive lines, active-low, exactly one bit low at any time
- onehot  output 16  committed key, bit index = row*4+col; zero = no key
- key_code  output 4  binary index of the last committed single key
- key_valid  output 1  one-cycle pulse when onehot changes to a new nonzero value

Behaviour:
- Reset (async, active-high) values:
  - row=4'b1110; onehot=0; key_code=0; key_valid=0.
  - Divider, row index, frame registers and debounce count cleared.
  - col synchronizer preset to 4'b1111.
  - Deasserting rst mid-scan restarts the scan at row 0.
- col passes through a 2-flop synchronizer before use.
- Scan:
  - Divider counts 0..SCAN_DIV-1. Row index advances 0..3, then wraps to 0, on the cycle the divider is at SCAN_DIV-1.
  - row = ~(1<<row_idx).
  - On the divider-terminal cycle, the synchronized ~col is written into frame bits [row_idx*4 +: 4]. Sampling at the end of the dwell gives settling time.
  - Frame-done strobe is asserted on the terminal cycle of row 3. Frame period = 4*SCAN_DIV cycles.
- Debounce, evaluated on frame-done:
  - If the new frame equals the previous frame: stable_cnt increments, saturating at DEBOUNCE_CNT. Otherwise stable_cnt = 1.
  - The previous frame is then replaced by the new frame.
  - When stable_cnt reaches DEBOUNCE_CNT, the frame is a candidate.
- Commit, on the cycle after frame-done, only if the candidate differs from the current onehot:
  - Exactly one bit set: onehot = frame; key_code = its index; key_valid = 1 for that one cycle.
  - Zero bits set: onehot = 0; key_code holds; no pulse.
  - Two or more bits set (multi-key or ghosting): onehot = 0; no pulse; key_code holds.
- Held key: onehot stays constant, and no repeat pulses are generated.
- Key change without release (A held, then B alone): onehot goes directly A -> B with one key_valid pulse.
- Latency:
  - Press stable from a frame start: commit DEBOUNCE_CNT frames later, plus 1 cycle.
  - Worst case: (DEBOUNCE_CNT+1)*4*SCAN_DIV + 3 cycles, including the synchronizer.
- Bounce shorter than one frame never reaches onehot, provided DEBOUNCE_CNT >= 2.
- Key index map, shared with the encoder:
  - Digits: 3='0', 7='1', 6='2', 5='3', 11='4', 10='5', 9='6', 15='7', 14='8', 13='9'.
  - Controls: 0=ENTER, 8=CLEAR_ALL, 12=CLEAR_ENTRY.
  - 1, 2, 4 unused. Unused keys are still reported.

Decomposition:
- Package keypad_pkg holds:
  - ROWS=4, COLS=4, KEY_W=16.
  - Key index constants KEY_0..KEY_9, KEY_ENTER, KEY_CLEAR_ALL, KEY_CLEAR_ENTRY.
  - Helper functions popcount16 and onehot_to_index.
- Sub-module keypad_debounce:
  - Inputs: frame, frame_done.
  - Outputs: committed onehot, key_code, key_valid.
  - Contains the stable counter and commit logic.
- keypad_scanner keeps the synchronizer, divider and row sequencer.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2; bench keypad model drives col = ~pressed bits of the active row):
- Reset asserted mid-scan at row 2 -> row=4'b1110 immediately (async); onehot=0, key_valid=0; scan restarts at row 0 after release.
- Press key index 6 ('2'), hold 200 cycles -> onehot=16'h0040, key_code=6, exactly one key_valid pulse within 3 frames+3 cycles. Release -> onehot=0 within 3 frames; no pulse.
- Press index 3 bouncing (toggle every 5 cycles for 20 cycles), then hold -> no commit during bounce; single commit onehot=16'h0008 after 2 stable frames.
- Hold index 0 (ENTER) and index 8 simultaneously -> onehot stays 0, no key_valid. Then release index 8 -> onehot=16'h0001 with one pulse.
- Hold index 15 ('7'), then switch directly to index 14 ('8') -> onehot 16'h8000 -> 16'h4000; two pulses total; key_code 15 then 14.
- Press for only 12 cycles (< one frame) -> onehot never leaves 0.
